// File: rtl/erx_pkg.sv
// Shared emesh definitions for the receive dispatcher: packet field offsets,
// channel numbering for type routing and a constant-evaluable clog2.
package erx_pkg;

    localparam int WRITE_BIT   = 0;
    localparam int DSTADDR_LSB = 8;
    localparam int DSTADDR_W   = 32;
    localparam int CHIPID_LSB  = 20;
    localparam int CHIPID_W    = 12;

    typedef enum logic [1:0] {
        CH_WRITE = 2'd0,
        CH_READ  = 2'd1,
        CH_RESP  = 2'd2
    } erx_type_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/erx_chfifo.sv
// One dispatch channel: a synchronous FIFO with MSB-toggle wrap pointers and
// an occupancy count. Storage is deliberately left out of reset.
module erx_chfifo
    import erx_pkg::*;
#(
    parameter int PW    = 104,
    parameter int DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           nreset,
    input  logic                           push,
    input  logic [PW-1:0]                  din,
    input  logic                           pop,
    output logic [PW-1:0]                  dout,
    output logic                           empty,
    output logic                           full,
    output logic [clog2(DEPTH):0]          count
);

    localparam int AW = clog2(DEPTH);

    logic [PW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;

    // A pop frees the slot in the same edge, so a full FIFO may still accept a push
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!nreset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/erx_dispatch.sv
// Receive-side dispatcher: steers each incoming emesh packet into a per-channel
// FIFO by packet type or destination address, with drop and stall monitoring.
module erx_dispatch
    import erx_pkg::*;
#(
    parameter int          PW     = 104,
    parameter int          NCH    = 3,
    parameter int          DEPTH  = 8,
    parameter int          MODE   = 0,
    parameter int          ASHIFT = 20,
    parameter logic [11:0] ID     = 12'h800,
    parameter int          AFULL  = 2,
    parameter int          TOW    = 12
) (
    input  logic                clk,
    input  logic                nreset,
    input  logic                rx_access,
    input  logic [PW-1:0]       rx_packet,
    output logic                rx_wait,
    output logic [NCH-1:0]      ch_access,
    output logic [NCH*PW-1:0]   ch_packet,
    input  logic [NCH-1:0]      ch_wait,
    output logic [NCH-1:0]      overflow,
    output logic [15:0]         drop_count,
    output logic [NCH-1:0]      timeout,
    input  logic                clear
);

    localparam int IW         = (clog2(NCH) < 1) ? 1 : clog2(NCH);
    localparam int AW         = clog2(DEPTH);
    localparam int WAIT_LEVEL = DEPTH - AFULL;
    localparam logic [TOW-1:0] TO_MAX = {TOW{1'b1}};
    localparam logic [TOW-1:0] TO_ARM = {{(TOW-1){1'b1}}, 1'b0};

    logic [IW-1:0]  sel;
    logic           sel_ok;
    logic [NCH-1:0] ch_push;
    logic [NCH-1:0] ch_pop;
    logic [NCH-1:0] ch_full;
    logic [NCH-1:0] ch_empty;
    logic [AW:0]    ch_count [NCH];
    logic [NCH-1:0] near_full;
    logic [NCH-1:0] ovf_set;
    logic [NCH-1:0] to_set;
    logic           drop;

    always_comb begin
        sel    = '0;
        sel_ok = 1'b0;
        if (MODE == 0) begin
            sel_ok = 1'b1;
            if (rx_packet[WRITE_BIT])
                sel = IW'(CH_WRITE);
            else if (rx_packet[DSTADDR_LSB + CHIPID_LSB +: CHIPID_W] == ID)
                sel = IW'(CH_RESP);
            else
                sel = IW'(CH_READ);
        end else begin
            sel    = rx_packet[DSTADDR_LSB + ASHIFT +: IW];
            sel_ok = (int'(sel) < NCH);
        end
    end

    genvar k;
    for (k = 0; k < NCH; k++) begin : g_ch
        logic           push_ok;
        logic [AW:0]    cnt_next;
        logic           stall;
        logic [TOW-1:0] stall_cnt;

        assign ch_push[k]   = rx_access && sel_ok && (int'(sel) == k);
        assign ch_pop[k]    = !ch_empty[k] && !ch_wait[k];
        assign ch_access[k] = !ch_empty[k];

        erx_chfifo #(
            .PW    (PW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk    (clk),
            .nreset (nreset),
            .push   (ch_push[k]),
            .din    (rx_packet),
            .pop    (ch_pop[k]),
            .dout   (ch_packet[k*PW +: PW]),
            .empty  (ch_empty[k]),
            .full   (ch_full[k]),
            .count  (ch_count[k])
        );

        // Look at post-edge occupancy so the registered rx_wait rises right after the crossing push
        assign push_ok      = ch_push[k] && (!ch_full[k] || ch_pop[k]);
        assign cnt_next     = ch_count[k] + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, ch_pop[k]};
        assign near_full[k] = (int'(cnt_next) >= WAIT_LEVEL);
        assign ovf_set[k]   = ch_push[k] && ch_full[k] && !ch_pop[k];

        assign stall     = !ch_empty[k] && ch_wait[k];
        assign to_set[k] = stall && (stall_cnt == TO_ARM);

        always_ff @(posedge clk) begin
            if (!nreset)
                stall_cnt <= '0;
            else if (!stall)
                stall_cnt <= '0;
            else if (stall_cnt != TO_MAX)
                stall_cnt <= stall_cnt + {{(TOW-1){1'b0}}, 1'b1};
        end
    end

    assign drop = (rx_access && !sel_ok) || (|ovf_set);

    // A drop coinciding with clear survives it: counter restarts at one
    always_ff @(posedge clk) begin
        if (!nreset) begin
            rx_wait    <= 1'b0;
            overflow   <= '0;
            timeout    <= '0;
            drop_count <= '0;
        end else begin
            rx_wait  <= |near_full;
            overflow <= (clear ? '0 : overflow) | ovf_set;
            timeout  <= (clear ? '0 : timeout) | to_set;
            if (drop)
                drop_count <= clear ? 16'd1 :
                              (drop_count == 16'hFFFF) ? drop_count : drop_count + 16'd1;
            else if (clear)
                drop_count <= '0;
        end
    end

endmodule

// File: tb/tb_erx_dispatch.sv
// Scoreboard bench for erx_dispatch: three configurations share one stimulus
// stream and are each checked against a queue-based model of the routing rules.
module tb_erx_dispatch;

    localparam int PW        = 104;
    localparam int DEPTH     = 8;
    localparam int AFULL     = 2;
    localparam int TOW       = 4;
    localparam int TO_LIMIT  = (1 << TOW) - 1;
    localparam int NINST     = 3;

    logic            clk = 1'b0;
    logic            nreset = 1'b0;
    logic            rx_access = 1'b0;
    logic [PW-1:0]   rx_packet = '0;
    logic [3:0]      ch_wait = 4'hF;
    logic            clear = 1'b0;

    logic            rxw_a, rxw_b, rxw_c;
    logic [2:0]      acc_a, acc_b, ovf_a, ovf_b, to_a, to_b;
    logic [3:0]      acc_c, ovf_c, to_c;
    logic [15:0]     dc_a, dc_b, dc_c;
    logic [3*PW-1:0] pk_a, pk_b;
    logic [4*PW-1:0] pk_c;

    logic [3:0]      acc [NINST];
    logic [3:0]      ovf [NINST];
    logic [3:0]      tmo [NINST];
    logic [15:0]     dc  [NINST];
    logic            rxw [NINST];

    int              total = 0;
    int              bad = 0;

    int              occ   [NINST][4];
    int              run   [NINST][4];
    logic [3:0]      m_ovf [NINST];
    logic [3:0]      m_to  [NINST];
    int              m_dc  [NINST];
    logic            m_rxw [NINST];
    logic [PW-1:0]   exp_q [NINST][4][$];

    always #5 clk = ~clk;

    erx_dispatch #(.PW(PW), .NCH(3), .DEPTH(DEPTH), .MODE(0), .ASHIFT(20),
                   .ID(12'h800), .AFULL(AFULL), .TOW(TOW)) dut_a (
        .clk(clk), .nreset(nreset), .rx_access(rx_access), .rx_packet(rx_packet),
        .rx_wait(rxw_a), .ch_access(acc_a), .ch_packet(pk_a), .ch_wait(ch_wait[2:0]),
        .overflow(ovf_a), .drop_count(dc_a), .timeout(to_a), .clear(clear));

    erx_dispatch #(.PW(PW), .NCH(3), .DEPTH(DEPTH), .MODE(1), .ASHIFT(20),
                   .ID(12'h800), .AFULL(AFULL), .TOW(TOW)) dut_b (
        .clk(clk), .nreset(nreset), .rx_access(rx_access), .rx_packet(rx_packet),
        .rx_wait(rxw_b), .ch_access(acc_b), .ch_packet(pk_b), .ch_wait(ch_wait[2:0]),
        .overflow(ovf_b), .drop_count(dc_b), .timeout(to_b), .clear(clear));

    erx_dispatch #(.PW(PW), .NCH(4), .DEPTH(DEPTH), .MODE(1), .ASHIFT(20),
                   .ID(12'h800), .AFULL(AFULL), .TOW(TOW)) dut_c (
        .clk(clk), .nreset(nreset), .rx_access(rx_access), .rx_packet(rx_packet),
        .rx_wait(rxw_c), .ch_access(acc_c), .ch_packet(pk_c), .ch_wait(ch_wait),
        .overflow(ovf_c), .drop_count(dc_c), .timeout(to_c), .clear(clear));

    always_comb begin
        acc[0] = {1'b0, acc_a}; acc[1] = {1'b0, acc_b}; acc[2] = acc_c;
        ovf[0] = {1'b0, ovf_a}; ovf[1] = {1'b0, ovf_b}; ovf[2] = ovf_c;
        tmo[0] = {1'b0, to_a};  tmo[1] = {1'b0, to_b};  tmo[2] = to_c;
        dc[0]  = dc_a;  dc[1]  = dc_b;  dc[2]  = dc_c;
        rxw[0] = rxw_a; rxw[1] = rxw_b; rxw[2] = rxw_c;
    end

    function automatic int nch_of(input int i);
        return (i == 2) ? 4 : 3;
    endfunction

    function automatic logic [PW-1:0] get_pkt(input int i, input int k);
        case (i)
            0:       return pk_a[k*PW +: PW];
            1:       return pk_b[k*PW +: PW];
            default: return pk_c[k*PW +: PW];
        endcase
    endfunction

    // Destination channel from the routing rules; -1 means the packet is dropped
    function automatic int route(input int i, input logic [PW-1:0] p);
        logic [31:0] dst;
        int          idx;
        dst = p[39:8];
        if (i == 0) begin
            if (p[0]) return 0;
            if (dst[31:20] == 12'h800) return 2;
            return 1;
        end
        idx = int'(dst[21:20]);
        return (idx < nch_of(i)) ? idx : -1;
    endfunction

    function automatic logic [PW-1:0] mk_pkt(input logic wr, input logic [31:0] dst);
        logic [127:0]  r;
        logic [PW-1:0] p;
        r = {$urandom, $urandom, $urandom, $urandom};
        p = r[PW-1:0];
        p[0] = wr;
        p[39:8] = dst;
        return p;
    endfunction

    task automatic cmp(input string name, input int i, input logic [31:0] got, input logic [31:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("[TB] FAIL %s inst%0d got=%0h exp=%0h at %0t", name, i, got, expv, $time);
        end
    endtask

    task automatic model_cycle(input int i);
        int         n, r;
        bit         drop;
        bit         pop [4];
        logic [3:0] ovf_set, to_set;
        n = nch_of(i);
        drop = 1'b0;
        ovf_set = '0;
        to_set = '0;
        for (int k = 0; k < 4; k++) pop[k] = 1'b0;
        for (int k = 0; k < n; k++) begin
            pop[k] = (occ[i][k] > 0) && !ch_wait[k];
            if ((occ[i][k] > 0) && ch_wait[k]) run[i][k]++;
            else run[i][k] = 0;
            if (run[i][k] == TO_LIMIT) to_set[k] = 1'b1;
        end
        if (rx_access) begin
            r = route(i, rx_packet);
            if (r < 0) drop = 1'b1;
            else if (occ[i][r] == DEPTH && !pop[r]) begin
                drop = 1'b1;
                ovf_set[r] = 1'b1;
            end else begin
                exp_q[i][r].push_back(rx_packet);
                occ[i][r]++;
            end
        end
        for (int k = 0; k < n; k++) if (pop[k]) occ[i][k]--;
        if (clear) begin
            m_ovf[i] = '0;
            m_to[i] = '0;
            m_dc[i] = 0;
        end
        m_ovf[i] |= ovf_set;
        m_to[i] |= to_set;
        if (drop && m_dc[i] < 65535) m_dc[i]++;
        m_rxw[i] = 1'b0;
        for (int k = 0; k < n; k++) if (occ[i][k] >= DEPTH - AFULL) m_rxw[i] = 1'b1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NINST; i++) begin
            for (int k = 0; k < 4; k++) begin
                occ[i][k] = 0;
                run[i][k] = 0;
                exp_q[i][k].delete();
            end
            m_ovf[i] = '0;
            m_to[i] = '0;
            m_dc[i] = 0;
            m_rxw[i] = 1'b0;
        end
    endtask

    task automatic checkOutput();
        for (int i = 0; i < NINST; i++) begin
            logic [3:0] mask, exp_acc;
            mask = (i == 2) ? 4'hF : 4'h7;
            exp_acc = '0;
            for (int k = 0; k < 4; k++) if (occ[i][k] > 0) exp_acc[k] = 1'b1;
            cmp("rx_wait",    i, {31'd0, rxw[i]},           {31'd0, m_rxw[i]});
            cmp("ch_access",  i, {28'd0, acc[i] & mask},    {28'd0, exp_acc});
            cmp("overflow",   i, {28'd0, ovf[i] & mask},    {28'd0, m_ovf[i]});
            cmp("timeout",    i, {28'd0, tmo[i] & mask},    {28'd0, m_to[i]});
            cmp("drop_count", i, {16'd0, dc[i]},            32'(m_dc[i]));
        end
    endtask

    // Drives one cycle of inputs, advances the model across the edge, then checks
    task automatic applyStimulus(input logic acc_i, input logic [PW-1:0] pkt_i,
                                 input logic [3:0] wait_i, input logic clr_i);
        rx_access = acc_i;
        rx_packet = pkt_i;
        ch_wait   = wait_i;
        clear     = clr_i;
        for (int i = 0; i < NINST; i++) model_cycle(i);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic reset_dut();
        rx_access = 1'b0;
        clear     = 1'b0;
        ch_wait   = 4'hF;
        nreset    = 1'b0;
        @(posedge clk);
        #1;
        nreset = 1'b1;
        model_reset();
        checkOutput();
    endtask

    task automatic idle(input int n, input logic [3:0] wait_i);
        for (int c = 0; c < n; c++) applyStimulus(1'b0, '0, wait_i, 1'b0);
    endtask

    // Packet monitor: every pop the DUT performs must match the oldest expected packet
    always @(negedge clk) begin
        logic [PW-1:0] e;
        for (int i = 0; i < NINST; i++) begin
            for (int k = 0; k < nch_of(i); k++) begin
                if (nreset === 1'b1 && acc[i][k] === 1'b1 && ch_wait[k] === 1'b0) begin
                    total++;
                    if (exp_q[i][k].size() == 0) begin
                        bad++;
                        $display("[TB] FAIL unexpected_pkt inst%0d ch%0d got=%0h exp=none", i, k, get_pkt(i, k));
                    end else begin
                        e = exp_q[i][k].pop_front();
                        if (get_pkt(i, k) !== e) begin
                            bad++;
                            $display("[TB] FAIL pkt inst%0d ch%0d got=%0h exp=%0h", i, k, get_pkt(i, k), e);
                        end
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] dst;
        logic [3:0]  w;
        model_reset();
        reset_dut();

        $display("[TB] routing by type and address");
        applyStimulus(1'b1, mk_pkt(1'b1, 32'h0000_0000), 4'h0, 1'b0);
        applyStimulus(1'b1, mk_pkt(1'b0, 32'h8000_0000), 4'h0, 1'b0);
        applyStimulus(1'b1, mk_pkt(1'b0, 32'h1000_0000), 4'h0, 1'b0);
        idle(3, 4'h0);

        $display("[TB] fill ch0 past full");
        for (int n = 0; n < 9; n++) applyStimulus(1'b1, mk_pkt(1'b1, 32'h0), 4'h1, 1'b0);
        idle(1, 4'h1);

        $display("[TB] push and pop at full");
        for (int n = 0; n < 3; n++) applyStimulus(1'b1, mk_pkt(1'b1, 32'h0), 4'h0, 1'b0);
        idle(10, 4'h0);

        $display("[TB] clear racing a drop");
        for (int n = 0; n < 8; n++) applyStimulus(1'b1, mk_pkt(1'b1, 32'h0), 4'h1, 1'b0);
        applyStimulus(1'b1, mk_pkt(1'b1, 32'h0), 4'h1, 1'b1);
        applyStimulus(1'b0, '0, 4'h1, 1'b1);
        idle(10, 4'h0);

        $display("[TB] stall timeout");
        applyStimulus(1'b1, mk_pkt(1'b0, 32'h1010_0000), 4'h2, 1'b0);
        idle(10, 4'h2);
        idle(2, 4'h0);
        applyStimulus(1'b1, mk_pkt(1'b0, 32'h1010_0000), 4'h2, 1'b0);
        idle(17, 4'h2);
        idle(2, 4'h0);
        applyStimulus(1'b0, '0, 4'h0, 1'b1);

        $display("[TB] out-of-range address index");
        for (int n = 0; n < 3; n++) applyStimulus(1'b1, mk_pkt(1'b1, 32'h0030_0000), 4'h0, 1'b0);
        idle(3, 4'h0);

        $display("[TB] reset with queued entries");
        for (int n = 0; n < 5; n++) applyStimulus(1'b1, mk_pkt(1'b1, 32'h0), 4'hF, 1'b0);
        reset_dut();
        applyStimulus(1'b1, mk_pkt(1'b1, 32'h0), 4'h0, 1'b0);
        applyStimulus(1'b1, mk_pkt(1'b0, 32'h8000_0000), 4'h0, 1'b0);
        idle(3, 4'h0);

        $display("[TB] random traffic");
        w = 4'h0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 11) == 0) w = 4'($urandom);
            case ($urandom_range(0, 3))
                0:       dst = {12'h800, 20'($urandom)};
                default: dst = $urandom;
            endcase
            applyStimulus(1'($urandom_range(0, 1)), mk_pkt(1'($urandom), dst), w,
                          ($urandom_range(0, 49) == 0));
        end

        idle(30, 4'h0);
        for (int i = 0; i < NINST; i++)
            for (int k = 0; k < nch_of(i); k++)
                cmp("drained", i, 32'(exp_q[i][k].size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
